// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four byte requesters.
// Define UART_TX_ARBITER_LOCK_EN to add the lock port, which lets one requester hold the channel for up to HOLD_MAX bytes.
module uart_tx_arbiter #(
   parameter int unsigned HOLD_MAX = 4
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic [3:0]  req,
   input  logic [31:0] din,
   input  logic        tx_ready,
`ifdef UART_TX_ARBITER_LOCK_EN
   input  logic [3:0]  lock,
`endif
   output logic [3:0]  ack,
   output logic [3:0]  gnt,
   output logic        busy,
   output logic        tx_start,
   output logic [7:0]  tx_data
);

   localparam int unsigned NREQ = 4;
   localparam int unsigned IW   = 2;
   localparam int unsigned DW   = 8;
   localparam int unsigned CW   = 4;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_ISSUE     = 2'd1,
      S_WAIT_BUSY = 2'd2,
      S_WAIT_DONE = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [NREQ-1:0] ack_q, ack_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            busy_q, busy_d;
   logic            tx_start_q, tx_start_d;
   logic [DW-1:0]   tx_data_q, tx_data_d;
   logic [IW-1:0]   last_q, last_d;
   logic [IW-1:0]   win_q, win_d;
   logic [CW-1:0]   cnt_q, cnt_d;

   logic [NREQ-1:0] lock_w;
   logic [IW-1:0]   rr_idx;
   logic [IW-1:0]   win_idx;
   logic            hold_ovr;
   logic [CW-1:0]   cnt_grant;

`ifdef UART_TX_ARBITER_LOCK_EN
   assign lock_w = lock;
`else
   // Without the lock feature the hold counter never leaves zero and is trimmed away.
   assign lock_w = '0;
`endif

   // Round-robin pick: closest requester after last; last itself has lowest priority.
   always_comb begin : rr_pick
      logic [IW-1:0] cand;
      cand   = last_q;
      rr_idx = last_q;
      for (int k = NREQ; k >= 1; k--) begin
         cand = last_q + IW'(k);
         if (req[cand]) rr_idx = cand;
      end
   end

   // A locked owner still inside its hold budget is granted again ahead of round-robin.
   always_comb begin
      hold_ovr  = (cnt_q != '0) && (cnt_q < CW'(HOLD_MAX)) && req[last_q];
      win_idx   = hold_ovr ? last_q : rr_idx;
      cnt_grant = '0;
      if (lock_w[win_idx]) cnt_grant = hold_ovr ? (cnt_q + CW'(1)) : CW'(1);
   end

   always_comb begin
      state_d    = state_q;
      ack_d      = '0;
      gnt_d      = gnt_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      last_d     = last_q;
      win_d      = win_q;
      cnt_d      = cnt_q;

      case (state_q)
         S_IDLE: begin
            if (tx_ready && (req != '0)) begin
               ack_d     = NREQ'(1) << win_idx;
               gnt_d     = NREQ'(1) << win_idx;
               tx_data_d = din[{win_idx, 3'b000} +: DW];
               win_d     = win_idx;
               cnt_d     = cnt_grant;
               state_d   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            tx_start_d = 1'b1;
            state_d    = S_WAIT_BUSY;
         end
         S_WAIT_BUSY: begin
            if (!tx_ready) state_d = S_WAIT_DONE;
         end
         S_WAIT_DONE: begin
            if (tx_ready) begin
               last_d  = win_q;
               gnt_d   = '0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         ack_q      <= '0;
         gnt_q      <= '0;
         busy_q     <= 1'b0;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
         last_q     <= IW'(NREQ - 1);
         win_q      <= '0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         ack_q      <= ack_d;
         gnt_q      <= gnt_d;
         busy_q     <= busy_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
         last_q     <= last_d;
         win_q      <= win_d;
         cnt_q      <= cnt_d;
      end
   end

   assign ack      = ack_q;
   assign gnt      = gnt_q;
   assign busy     = busy_q;
   assign tx_start = tx_start_q;
   assign tx_data  = tx_data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized self-checking bench for uart_tx_arbiter against a transaction-level reference model.
module tb_uart_tx_arbiter;

   localparam int HOLD = 4;

   logic        clk = 1'b0;
   logic        rstn = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] din = '0;
   logic        tx_ready = 1'b1;
`ifdef UART_TX_ARBITER_LOCK_EN
   logic [3:0]  lock = '0;
`endif
   logic [3:0]  ack;
   logic [3:0]  gnt;
   logic        busy;
   logic        tx_start;
   logic [7:0]  tx_data;

   uart_tx_arbiter #(.HOLD_MAX(HOLD)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .req      (req),
      .din      (din),
      .tx_ready (tx_ready),
`ifdef UART_TX_ARBITER_LOCK_EN
      .lock     (lock),
`endif
      .ack      (ack),
      .gnt      (gnt),
      .busy     (busy),
      .tx_start (tx_start),
      .tx_data  (tx_data)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: one byte in flight, tracked by cycles since its ack.
   bit         m_busy = 0;
   bit         m_seen_low = 0;
   int         m_since = 0;
   int         m_last = 3;
   int         m_cur = 0;
   int         m_cnt = 0;
   logic [3:0] e_ack = '0;
   logic [3:0] e_gnt = '0;
   logic [7:0] e_data = '0;
   logic       e_start = 1'b0;

   // Transmitter model.
   int         xm_left = 0;
   bit         force_low = 0;
   int         dur_min = 1;
   int         dur_max = 4;
   logic [7:0] sent_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      logic [3:0] lk;
      int w;
      int old;
      bit ovr;
      bit found;
`ifdef UART_TX_ARBITER_LOCK_EN
      lk = lock;
`else
      lk = '0;
`endif
      e_ack = '0;
      if (!m_busy) begin
         if (tx_ready && req != 4'b0) begin
            ovr   = (m_cnt > 0) && (m_cnt < HOLD) && req[m_last];
            w     = m_last;
            found = 0;
            if (!ovr) begin
               for (int k = 1; k <= 4; k++) begin
                  if (!found && req[(m_last + k) % 4]) begin
                     w = (m_last + k) % 4;
                     found = 1;
                  end
               end
            end
            m_cnt      = lk[w] ? (ovr ? m_cnt + 1 : 1) : 0;
            m_cur      = w;
            m_busy     = 1;
            m_since    = 0;
            m_seen_low = 0;
            e_ack      = 4'(1 << w);
            e_gnt      = e_ack;
            e_data     = din[8*w +: 8];
         end
      end else begin
         old = m_since;
         if (m_seen_low && tx_ready) begin
            m_busy = 0;
            e_gnt  = '0;
            m_last = m_cur;
         end else if (old >= 1 && !tx_ready) begin
            m_seen_low = 1;
         end
         m_since = old + 1;
      end
      e_start = m_busy && (m_since == 1);

      @(posedge clk);
      #1;
      chk("ack", 32'(ack), 32'(e_ack));
      chk("gnt", 32'(gnt), 32'(e_gnt));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tx_start", 32'(tx_start), 32'(e_start));
      chk("tx_data", 32'(tx_data), 32'(e_data));

      if (tx_start) begin
         sent_q.push_back(tx_data);
         xm_left = $urandom_range(dur_max, dur_min);
      end
      if (xm_left > 0) begin
         tx_ready = 1'b0;
         xm_left--;
      end else begin
         tx_ready = !force_low;
      end
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      #2;
      chk("rst_ack", 32'(ack), 32'h0);
      chk("rst_gnt", 32'(gnt), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_tx_start", 32'(tx_start), 32'h0);
      chk("rst_tx_data", 32'(tx_data), 32'h0);
      m_busy = 0; m_seen_low = 0; m_since = 0; m_last = 3; m_cnt = 0;
      e_ack = '0; e_gnt = '0; e_data = '0; e_start = 1'b0;
      xm_left = 0; force_low = 0; tx_ready = 1'b1;
      @(posedge clk);
      #1;
      rstn = 1'b1;
   endtask

   logic [7:0] exp5[6];

   initial begin
      #1;
      do_reset();

      // Single requester, single byte.
      req = 4'b0001; din = 32'h0000_0041;
      tick();
      chk("t1_ack", 32'(ack), 32'h1);
      chk("t1_data", 32'(tx_data), 32'h41);
      chk("t1_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      tick();
      chk("t1_start", 32'(tx_start), 32'h1);
      for (int i = 0; i < 10; i++) tick();
      chk("t1_sent_n", 32'(sent_q.size()), 32'd1);
      if (sent_q.size() > 0) chk("t1_sent", 32'(sent_q[0]), 32'h41);

      // All four requesting: round-robin order from reset.
      do_reset();
      sent_q.delete();
      dur_min = 3; dur_max = 3;
      req = 4'b1111; din = 32'h4030_2010;
      for (int i = 0; i < 100 && sent_q.size() < 5; i++) tick();
      chk("t2_sent_n", 32'(sent_q.size() >= 5), 32'h1);
      if (sent_q.size() >= 5) begin
         chk("t2_b0", 32'(sent_q[0]), 32'h10);
         chk("t2_b1", 32'(sent_q[1]), 32'h20);
         chk("t2_b2", 32'(sent_q[2]), 32'h30);
         chk("t2_b3", 32'(sent_q[3]), 32'h40);
         chk("t2_b4", 32'(sent_q[4]), 32'h10);
      end

      // Request held off while the transmitter is not ready.
      do_reset();
      force_low = 1; tx_ready = 1'b0;
      req = 4'b0100; din = 32'h00AB_0000;
      for (int i = 0; i < 20; i++) tick();
      chk("t3_busy_idle", 32'(busy), 32'h0);
      force_low = 0; tx_ready = 1'b1;
      tick();
      chk("t3_ack", 32'(ack), 32'h4);
      req = 4'b0000;
      for (int i = 0; i < 12; i++) tick();

      // Reset during WAIT_DONE, then requester 0 wins over 3.
      do_reset();
      dur_min = 6; dur_max = 6;
      req = 4'b0001; din = 32'h0000_0055;
      tick();
      req = 4'b0000;
      for (int i = 0; i < 30 && !(m_busy && m_seen_low); i++) tick();
      chk("t4_busy_pre", 32'(busy), 32'h1);
      do_reset();
      req = 4'b1001; din = 32'h7700_0066;
      tick();
      chk("t4_ack", 32'(ack), 32'h1);
      chk("t4_data", 32'(tx_data), 32'h66);
      req = 4'b0000;
      for (int i = 0; i < 12; i++) tick();

      // Two requesters, requester 0 asking for the lock.
      do_reset();
      sent_q.delete();
      dur_min = 2; dur_max = 2;
`ifdef UART_TX_ARBITER_LOCK_EN
      lock = 4'b0001;
      exp5[0] = 8'hA0; exp5[1] = 8'hA0; exp5[2] = 8'hA0;
      exp5[3] = 8'hA0; exp5[4] = 8'hB1; exp5[5] = 8'hA0;
`else
      exp5[0] = 8'hA0; exp5[1] = 8'hB1; exp5[2] = 8'hA0;
      exp5[3] = 8'hB1; exp5[4] = 8'hA0; exp5[5] = 8'hB1;
`endif
      req = 4'b0011; din = 32'h0000_B1A0;
      for (int i = 0; i < 150 && sent_q.size() < 6; i++) tick();
      chk("t5_sent_n", 32'(sent_q.size() >= 6), 32'h1);
      if (sent_q.size() >= 6) begin
         for (int i = 0; i < 6; i++) chk($sformatf("t5_b%0d", i), 32'(sent_q[i]), 32'(exp5[i]));
      end

      // Random traffic.
      do_reset();
      dur_min = 1; dur_max = 4;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 3) == 0) req = 4'($urandom);
         if ($urandom_range(0, 1) == 0) din = $urandom;
`ifdef UART_TX_ARBITER_LOCK_EN
         if ($urandom_range(0, 7) == 0) lock = 4'($urandom);
`endif
         if ($urandom_range(0, 19) == 0) force_low = !force_low;
         if ($urandom_range(0, 299) == 0) do_reset();
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
